de2_70_nios_div_cell: RTL and testbench
=======================================

# de2_70_nios_div_cell

Iterative 32-bit integer divider for the Nios custom arithmetic path. It is the inverse counterpart of the multiply cell: it takes a dividend and a divisor and returns a quotient and a remainder. Operands are signed or unsigned, and the algorithm is restoring radix-2 with one quotient bit per clock. It sits beside the multiply cell in the A-stage and is controlled by the CPU with a start/busy/done handshake.

## Interface
Parameters: none. Width is fixed at 32.

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- A_div_start  in  1  request a divide; sampled only when idle
- A_div_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- A_div_src1  in  32  dividend; sampled with start
- A_div_src2  in  32  divisor; sampled with start
- A_div_busy  out  1  operation in progress
- A_div_done  out  1  one-cycle pulse; results valid
- A_div_quotient  out  32  quotient, registered
- A_div_remainder  out  32  remainder, registered

## Operation
- States: IDLE, ITER, FIX.
- IDLE, with A_div_start=1:
  - Latch sign flags: neg_a = signed & src1[31], neg_b = signed & src2[31].
  - Latch magnitudes |src1| and |src2| as 32-bit unsigned. |0x80000000| = 0x80000000.
  - Latch div_zero = (src2 == 0) and the raw src1.
  - Clear the 33-bit partial remainder, load the quotient shift register with |src1|, set iteration counter = 0, go to ITER.
- ITER, each cycle:
  - Shift {prem, qreg} left by 1.
  - trial = prem − {1'b0, |src2|}, computed 33 bits wide.
  - If trial is non-negative: prem = trial, qreg[0] = 1. Otherwise qreg[0] = 0.
  - The counter increments. After the 32nd ITER cycle (counter = 31), go to FIX.
- FIX, one cycle:
  - Quotient = neg_a ^ neg_b ? −qreg : qreg.
  - Remainder = neg_a ? −prem[31:0] : prem[31:0].
  - Both are registered to the outputs. A_div_done is pulsed and the state returns to IDLE.
- Sign rules: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (either mode): quotient = 0xFFFFFFFF, remainder = latched src1. This overrides the FIX arithmetic. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: the natural datapath result is quotient 0x80000000, remainder 0. No trap.
- A_div_start while busy is ignored. Operands are not re-sampled and the in-flight operation is unaffected.
- Outputs hold their last result until the next FIX. Nothing changes them in IDLE.

## Timing
- Reset (synchronous, highest priority):
  - state = IDLE, A_div_busy = 0, A_div_done = 0, A_div_quotient = 0, A_div_remainder = 0, counter = 0.
  - Reset mid-operation aborts the operation: no done pulse, busy is 0 from the cycle after reset is sampled.
- Start sampled at the edge ending cycle 0:
  - Cycles 1–32: ITER.
  - Cycle 33: FIX.
  - Cycle 34: A_div_done = 1 and results are valid.
  - Latency is 34 cycles from start to done, fixed for all operands including divide by zero.
- A_div_busy = 1 in cycles 1–33. It falls in the same cycle that A_div_done rises.
- A_div_done is high for exactly one cycle.
- Back-to-back operation: start asserted in the done cycle (cycle 34) is accepted, because the state is IDLE. The next done arrives 34 cycles later. Maximum throughput is one divide per 34 cycles.
- Start and reset in the same cycle: reset wins and start is dropped.

## Test plan
- Unsigned 100 / 7 → done in cycle 34, quotient 0x0000000E, remainder 0x00000002, busy high in cycles 1–33 only.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x12345678 / 0, in both modes → quotient 0xFFFFFFFF, remainder 0x12345678, latency 34.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 0xFFFFFFFF → quotient 1, remainder 0.
- Start 1000 / 3. Pulse start with 5 / 1 in cycle 10 → that pulse is ignored; the result is quotient 333, remainder 1 in cycle 34. Start 9 / 4 in cycle 34 → quotient 2, remainder 1 in cycle 68.
- Reset asserted in cycle 12 of an operation → busy 0 and outputs 0 from cycle 13, no done pulse. A following 50 / 5 → quotient 10, remainder 0 after 34 cycles.

Source files
------------

// File: rtl/de2_70_nios_div_cell_if.sv
// Start/busy/done handshake and operand/result bus between the CPU A-stage and the divide cell.
// master = CPU side, slave = divider side.
interface de2_70_nios_div_cell_if;
  logic        A_div_start;
  logic        A_div_signed;
  logic [31:0] A_div_src1;
  logic [31:0] A_div_src2;
  logic        A_div_busy;
  logic        A_div_done;
  logic [31:0] A_div_quotient;
  logic [31:0] A_div_remainder;

  modport master (
    output A_div_start, A_div_signed, A_div_src1, A_div_src2,
    input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );

  modport slave (
    input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
    output A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );
endinterface

// File: rtl/de2_70_nios_div_cell.sv
// Restoring radix-2 32-bit signed/unsigned divider, one quotient bit per clock; done 34 cycles after start.
// No backpressure: start is ignored while busy, results hold until the next operation completes.
module de2_70_nios_div_cell (
  input  logic                          clk,
  input  logic                          reset,
  de2_70_nios_div_cell_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        dz_q, dz_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [32:0] prem_q, prem_d;
  logic [31:0] qreg_q, qreg_d;

  logic        neg_a_w, neg_b_w;
  logic [31:0] mag_a_w, mag_b_w;
  logic [33:0] trial_w;

  assign neg_a_w = bus.A_div_signed & bus.A_div_src1[31];
  assign neg_b_w = bus.A_div_signed & bus.A_div_src2[31];
  // Two's-complement negate also maps 0x80000000 onto itself, which is its correct unsigned magnitude.
  assign mag_a_w = neg_a_w ? (~bus.A_div_src1 + 32'd1) : bus.A_div_src1;
  assign mag_b_w = neg_b_w ? (~bus.A_div_src2 + 32'd1) : bus.A_div_src2;
  assign trial_w = {prem_q, qreg_q[31]} - {2'b00, mag_b_q};

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    src1_d  = src1_q;
    mag_b_d = mag_b_q;
    prem_d  = prem_q;
    qreg_d  = qreg_q;
    case (state_q)
      IDLE: begin
        if (bus.A_div_start) begin
          neg_a_d = neg_a_w;
          neg_b_d = neg_b_w;
          dz_d    = (bus.A_div_src2 == 32'd0);
          src1_d  = bus.A_div_src1;
          mag_b_d = mag_b_w;
          prem_d  = 33'd0;
          qreg_d  = mag_a_w;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        // Partial remainder stays below the divisor, so the 34-bit trial sign is exact.
        prem_d  = trial_w[33] ? (trial_w[32:0] + {1'b0, mag_b_q}) : trial_w[32:0];
        qreg_d  = {qreg_q[30:0], ~trial_w[33]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          quot_d = 32'hFFFF_FFFF;
          rem_d  = src1_q;
        end else begin
          quot_d = (neg_a_q ^ neg_b_q) ? (~qreg_q + 32'd1) : qreg_q;
          rem_d  = neg_a_q ? (~prem_q[31:0] + 32'd1) : prem_q[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      cnt_q   <= 5'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      src1_q  <= 32'd0;
      mag_b_q <= 32'd0;
      prem_q  <= 33'd0;
      qreg_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      src1_q  <= src1_d;
      mag_b_q <= mag_b_d;
      prem_q  <= prem_d;
      qreg_q  <= qreg_d;
    end
  end

  assign bus.A_div_busy      = busy_q;
  assign bus.A_div_done      = done_q;
  assign bus.A_div_quotient  = quot_q;
  assign bus.A_div_remainder = rem_q;

endmodule

// File: tb/tb_de2_70_nios_div_cell.sv
// Directed bench for the divide cell: a behavioural model fills a scoreboard at start, a monitor checks each done.
module tb_de2_70_nios_div_cell;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  de2_70_nios_div_cell_if div_if ();

  de2_70_nios_div_cell dut (
    .clk   (clk),
    .reset (reset),
    .bus   (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  // Truncating division with the divide-by-zero and overflow results the cell defines.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  always @(negedge clk) begin
    if (div_if.A_div_done === 1'b1) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL spurious_done: observed done at cycle %0d expected none", cyc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_quotient", div_if.A_div_quotient, e.q);
        chk("sb_remainder", div_if.A_div_remainder, e.r);
        chk("sb_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start for one cycle; operands are scrambled afterwards to prove they were latched.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    div_if.A_div_start  = 1'b1;
    div_if.A_div_signed = sgn;
    div_if.A_div_src1   = a;
    div_if.A_div_src2   = b;
    if (push) begin
      model(sgn, a, b, e.q, e.r);
      e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    div_if.A_div_start  = 1'b0;
    div_if.A_div_signed = 1'($urandom);
    div_if.A_div_src1   = $urandom;
    div_if.A_div_src2   = $urandom;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er);
    bit bad;
    bad = 1'b0;
    start_op(sgn, a, b, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      if (div_if.A_div_busy !== (k <= 33) || div_if.A_div_done !== (k == 34)) bad = 1'b1;
      if (k < 34) @(negedge clk);
    end
    chk({name, "_busy_done_profile"}, {31'd0, bad}, 32'd0);
    chk({name, "_quotient"}, div_if.A_div_quotient, eq);
    chk({name, "_remainder"}, div_if.A_div_remainder, er);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr;
    logic        rs;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    div_if.A_div_start  = 1'b0;
    div_if.A_div_signed = 1'b0;
    div_if.A_div_src1   = 32'd0;
    div_if.A_div_src2   = 32'd0;
    step(3);
    chk("reset_busy", {31'd0, div_if.A_div_busy}, 32'd0);
    chk("reset_done", {31'd0, div_if.A_div_done}, 32'd0);
    chk("reset_quotient", div_if.A_div_quotient, 32'd0);
    chk("reset_remainder", div_if.A_div_remainder, 32'd0);
    reset = 1'b0;
    step(1);

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    run_op("u_div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("s_div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_op("s_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = (i < 4) ? ($urandom >> (i * 7)) : $urandom_range(1, 300);
      model(rs, ra, rb, rq, rr);
      run_op("rand", rs, ra, rb, rq, rr);
    end

    // Start pulse mid-operation must be ignored; back-to-back start in the done cycle is accepted.
    start_op(1'b0, 32'd1000, 32'd3, 1'b1);
    step(9);
    start_op(1'b0, 32'd5, 32'd1, 1'b0);
    step(23);
    chk("b2b_first_quotient", div_if.A_div_quotient, 32'd333);
    chk("b2b_first_remainder", div_if.A_div_remainder, 32'd1);
    start_op(1'b0, 32'd9, 32'd4, 1'b1);
    step(33);
    chk("b2b_second_quotient", div_if.A_div_quotient, 32'd2);
    chk("b2b_second_remainder", div_if.A_div_remainder, 32'd1);
    drain();

    // Reset in cycle 12 of an operation aborts it with no done pulse.
    start_op(1'b0, 32'd77, 32'd3, 1'b1);
    step(11);
    reset = 1'b1;
    sb.delete();
    step(1);
    reset = 1'b0;
    chk("abort_busy", {31'd0, div_if.A_div_busy}, 32'd0);
    chk("abort_quotient", div_if.A_div_quotient, 32'd0);
    chk("abort_remainder", div_if.A_div_remainder, 32'd0);
    step(40);
    run_op("after_abort", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    // Start coinciding with reset is dropped.
    div_if.A_div_start = 1'b1;
    div_if.A_div_src1  = 32'd20;
    div_if.A_div_src2  = 32'd3;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    div_if.A_div_start = 1'b0;
    step(1);
    chk("rst_start_busy", {31'd0, div_if.A_div_busy}, 32'd0);
    step(40);
    chk("rst_start_quotient", div_if.A_div_quotient, 32'd0);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
